// File: rtl/csr_exec.sv
// CSR execution unit: decodes one CSR instruction at issue, drives the csrfile
// request channel, and returns the old value for writeback or raises an illegal-instruction trap.
module csr_exec (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_issue_valid,
  output logic        o_issue_ready,
  input  logic [31:0] i_issue_instr,
  input  logic [31:0] i_issue_rs1,
  output logic        o_req_valid,
  input  logic        i_req_ready,
  output logic [11:0] o_req_a,
  output logic [1:0]  o_req_t,
  output logic [31:0] o_req_d,
  input  logic        i_resp_exists,
  input  logic [31:0] i_resp_d,
  output logic        o_wb_valid,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data,
  output logic        o_ex_valid,
  output logic [4:0]  o_ex_cause,
  output logic [31:0] o_ex_tval,
  output logic        o_op_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] T_CSRS = 2'b10;

  state_t r_state;
  state_t w_next;

  logic [11:0] r_a;
  logic [1:0]  r_t;
  logic [31:0] r_d;
  logic [4:0]  r_rd;
  logic [31:0] r_instr;
  logic        r_illegal;
  logic        r_exists;
  logic [31:0] r_wb_data;

  logic [2:0]  w_funct3;
  logic [4:0]  w_src;
  logic [11:0] w_csr;
  logic [4:0]  w_rd;
  logic        w_write;
  logic        w_illegal;
  logic [31:0] w_operand;
  logic        w_fire;
  logic        w_handshake;
  logic        w_fault;

  assign w_funct3    = i_issue_instr[14:12];
  assign w_src       = i_issue_instr[19:15];
  assign w_csr       = i_issue_instr[31:20];
  assign w_rd        = i_issue_instr[11:7];
  assign w_write     = (w_funct3[1:0] == 2'b01) || (w_src != 5'd0);
  assign w_illegal   = (w_funct3[1:0] == 2'b00) || (w_write && (w_csr[11:10] == 2'b11));
  assign w_operand   = w_funct3[2] ? {27'd0, w_src} : i_issue_rs1;
  assign w_fire      = (r_state == S_IDLE) && i_issue_valid;
  assign w_handshake = (r_state == S_REQ) && i_req_ready;
  assign w_fault     = r_illegal || !r_exists;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_issue_valid) w_next = w_illegal ? S_DONE : S_REQ;
      S_REQ:  if (i_req_ready)   w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Pure reads (S/C with src = 0) go out as CSRS with zero data so csrfile treats them uniformly.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a       <= '0;
      r_t       <= '0;
      r_d       <= '0;
      r_rd      <= '0;
      r_instr   <= '0;
      r_illegal <= 1'b0;
      r_exists  <= 1'b1;
      r_wb_data <= '0;
    end else begin
      if (w_fire) begin
        r_a       <= w_csr;
        r_t       <= w_write ? w_funct3[1:0] : T_CSRS;
        r_d       <= w_write ? w_operand : '0;
        r_rd      <= w_rd;
        r_instr   <= i_issue_instr;
        r_illegal <= w_illegal;
        r_exists  <= 1'b1;
      end
      if (w_handshake) begin
        r_wb_data <= i_resp_d;
        r_exists  <= i_resp_exists;
      end
    end
  end

  always_comb begin
    o_issue_ready = 1'b0;
    o_req_valid   = 1'b0;
    o_op_done     = 1'b0;
    o_ex_valid    = 1'b0;
    o_wb_valid    = 1'b0;
    case (r_state)
      S_IDLE: o_issue_ready = 1'b1;
      S_REQ:  o_req_valid   = 1'b1;
      S_DONE: begin
        o_op_done  = 1'b1;
        o_ex_valid = w_fault;
        o_wb_valid = !w_fault && (r_rd != 5'd0);
      end
      default: o_issue_ready = 1'b0;
    endcase
  end

  assign o_req_a    = r_a;
  assign o_req_t    = r_t;
  assign o_req_d    = r_d;
  assign o_wb_rd    = r_rd;
  assign o_wb_data  = r_wb_data;
  assign o_ex_cause = 5'd2;
  assign o_ex_tval  = r_instr;

endmodule

// File: tb/tb_csr_exec.sv
// Self-checking bench for csr_exec: behavioural csrfile plus a transaction-level
// expectation model, directed cases with literal expectations, then randomized traffic.
module tb_csr_exec;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] issue_instr;
  logic [31:0] issue_rs1;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_a;
  logic [1:0]  req_t;
  logic [31:0] req_d;
  logic        resp_exists;
  logic [31:0] resp_d;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic [4:0]  ex_cause;
  logic [31:0] ex_tval;
  logic        op_done;

  csr_exec dut (
    .i_clk(clk), .i_rst(rst),
    .i_issue_valid(issue_valid), .o_issue_ready(issue_ready),
    .i_issue_instr(issue_instr), .i_issue_rs1(issue_rs1),
    .o_req_valid(req_valid), .i_req_ready(req_ready),
    .o_req_a(req_a), .o_req_t(req_t), .o_req_d(req_d),
    .i_resp_exists(resp_exists), .i_resp_d(resp_d),
    .o_wb_valid(wb_valid), .o_wb_rd(wb_rd), .o_wb_data(wb_data),
    .o_ex_valid(ex_valid), .o_ex_cause(ex_cause), .o_ex_tval(ex_tval),
    .o_op_done(op_done)
  );

  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  bit          chk_en = 0;
  bit          rand_en = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural csrfile ----------------
  logic [31:0] mem [0:4095];
  logic [31:0] mcycle;
  logic [31:0] hs_val;
  bit          inited = 0;
  int unsigned wait_c;

  function automatic bit csr_exists(input logic [11:0] a);
    return a != 12'h7C0;
  endfunction

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      req_ready   = 1'b0;
      resp_exists = 1'b0;
      resp_d      = '0;
      wait_c      = 1;
    end else if (req_valid) begin
      if (wait_c == 0) begin
        req_ready   = 1'b1;
        resp_exists = csr_exists(req_a);
        resp_d      = (req_a == 12'hB00) ? mcycle : mem[req_a];
      end else begin
        wait_c--;
      end
    end else begin
      req_ready = 1'b0;
      wait_c    = 1 + (rand_en ? $urandom_range(0, 2) : 0);
    end
  end

  always @(posedge clk) begin
    logic [31:0] nv;
    if (!inited) begin
      for (int i = 0; i < 4096; i++) mem[i] = '0;
      mem[12'h340] = 32'h11;
      mem[12'hF11] = 32'h489;
      mem[12'hF14] = 32'h3;
      mcycle = 32'd1000;
      inited = 1;
    end
    if (!rst && req_valid && req_ready) begin
      hs_val = resp_d;
      case (req_t)
        2'b01:   nv = req_d;
        2'b10:   nv = resp_d | req_d;
        default: nv = resp_d & ~req_d;
      endcase
      if (req_a == 12'hB00) mcycle = nv;
      else begin
        if (csr_exists(req_a)) mem[req_a] = nv;
        mcycle = mcycle + 1;
      end
    end else begin
      mcycle = mcycle + 1;
    end
  end

  // ---------------- transaction-level expectation model ----------------
  bit          m_busy, m_inreq, m_done, m_ex, m_wb;
  logic [11:0] m_a;
  logic [1:0]  m_t;
  logic [31:0] m_d, m_instr, m_data;
  logic [4:0]  m_rd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_inreq = 0; m_done = 0; m_ex = 0; m_wb = 0;
    end else if (m_done) begin
      m_done = 0;
      m_busy = 0;
    end else if (m_inreq && req_ready) begin
      m_inreq = 0;
      m_done  = 1;
      m_ex    = !resp_exists;
      m_wb    = resp_exists && (m_rd != 0);
      m_data  = resp_d;
    end else if (!m_busy && issue_valid) begin
      logic [2:0] f3;
      logic [4:0] src;
      bit         writes, bad;
      f3      = issue_instr[14:12];
      src     = issue_instr[19:15];
      m_a     = issue_instr[31:20];
      m_rd    = issue_instr[11:7];
      m_instr = issue_instr;
      writes  = (f3[1:0] == 2'b01) || (src != 0);
      bad     = (f3[1:0] == 2'b00) || (writes && m_a >= 12'hC00);
      m_t     = writes ? f3[1:0] : 2'b10;
      m_d     = !writes ? 32'd0 : (f3[2] ? 32'(src) : issue_rs1);
      m_busy  = 1;
      if (bad) begin
        m_done = 1; m_ex = 1; m_wb = 0;
      end else begin
        m_inreq = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_issue_ready", 32'(issue_ready), 32'(!m_busy));
      chk("m_req_valid",   32'(req_valid),   32'(m_inreq));
      if (m_inreq) begin
        chk("m_req_a", 32'(req_a), 32'(m_a));
        chk("m_req_t", 32'(req_t), 32'(m_t));
        chk("m_req_d", req_d, m_d);
      end
      chk("m_op_done",  32'(op_done),  32'(m_done));
      chk("m_ex_valid", 32'(ex_valid), 32'(m_done && m_ex));
      chk("m_wb_valid", 32'(wb_valid), 32'(m_done && m_wb));
      if (m_done && m_wb) begin
        chk("m_wb_rd",   32'(wb_rd), 32'(m_rd));
        chk("m_wb_data", wb_data,    m_data);
      end
      if (m_done && m_ex) chk("m_ex_tval", ex_tval, m_instr);
      chk("m_ex_cause", 32'(ex_cause), 32'd2);
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] mk(input logic [11:0] csr, input logic [4:0] src,
                                     input logic [2:0] f3, input logic [4:0] rd);
    return {csr, src, f3, rd, 7'h73};
  endfunction

  task automatic issue(input logic [31:0] instr, input logic [31:0] rs1);
    int unsigned t = 0;
    @(negedge clk);
    while (!issue_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) begin
      n_chk++;
      n_fail++;
      $display("FAIL issue_timeout: issue_ready stayed 0 for %0d cycles, required 1", t);
    end
    issue_valid = 1'b1;
    issue_instr = instr;
    issue_rs1   = rs1;
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
  endtask

  // Cycle c is the c-th negedge after the issuing edge E0.
  task automatic run_dir(input string name, input logic [31:0] instr, input logic [31:0] rs1,
                         input int req_last, input int wb_c, input int ex_c, input int done_c,
                         input int idle_c, input logic [4:0] rd, input logic [31:0] data,
                         input bit chk_data);
    issue(instr, rs1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      chk($sformatf("%s c%0d req_valid", name, c),   32'(req_valid),   32'(c <= req_last));
      chk($sformatf("%s c%0d wb_valid", name, c),    32'(wb_valid),    32'(c == wb_c));
      chk($sformatf("%s c%0d ex_valid", name, c),    32'(ex_valid),    32'(c == ex_c));
      chk($sformatf("%s c%0d op_done", name, c),     32'(op_done),     32'(c == done_c));
      chk($sformatf("%s c%0d issue_ready", name, c), 32'(issue_ready), 32'(c >= idle_c));
      if (c == wb_c) begin
        chk($sformatf("%s wb_rd", name), 32'(wb_rd), 32'(rd));
        if (chk_data) chk($sformatf("%s wb_data", name), wb_data, data);
      end
      if (c == ex_c) begin
        chk($sformatf("%s ex_cause", name), 32'(ex_cause), 32'd2);
        chk($sformatf("%s ex_tval", name),  ex_tval,       instr);
      end
    end
  endtask

  initial begin
    logic [11:0] csrs [10];
    csrs = '{12'h300, 12'h305, 12'h340, 12'h341, 12'hB00,
             12'hC00, 12'hF11, 12'hF14, 12'h7C0, 12'h3A0};
    rst = 1'b1;
    issue_valid = 1'b0;
    issue_instr = '0;
    issue_rs1   = '0;
    repeat (2) @(negedge clk);
    chk("rst issue_ready", 32'(issue_ready), 32'd1);
    chk("rst req_valid",   32'(req_valid),   32'd0);
    chk("rst wb_valid",    32'(wb_valid),    32'd0);
    chk("rst ex_valid",    32'(ex_valid),    32'd0);
    chk("rst op_done",     32'(op_done),     32'd0);
    chk("rst wb_rd",       32'(wb_rd),       32'd0);
    chk("rst wb_data",     wb_data,          32'd0);
    chk("rst ex_tval",     ex_tval,          32'd0);
    chk("rst ex_cause",    32'(ex_cause),    32'd2);
    #1 rst = 1'b0;
    chk_en = 1;

    run_dir("csrrw_mscratch", mk(12'h340, 5'd6, 3'b001, 5'd5), 32'hDEADBEEF,
            2, 3, 0, 3, 4, 5'd5, 32'h11, 1);
    chk("mscratch readback", mem[12'h340], 32'hDEADBEEF);

    run_dir("csrrsi_mstatus", mk(12'h300, 5'd8, 3'b110, 5'd0), 32'h0,
            2, 0, 0, 3, 4, 5'd0, 32'h0, 0);
    chk("mstatus value", mem[12'h300], 32'h8);

    run_dir("csrrs_mcycle", mk(12'hB00, 5'd0, 3'b010, 5'd7), 32'h0,
            2, 3, 0, 3, 4, 5'd7, 32'h0, 0);
    chk("mcycle wb_data", wb_data, hs_val);
    chk("mcycle sampled after start", 32'(hs_val > 32'd1000), 32'd1);

    run_dir("csrrw_mvendorid", mk(12'hF11, 5'd1, 3'b001, 5'd1), 32'h1,
            0, 0, 1, 1, 2, 5'd0, 32'h0, 0);
    chk("mvendorid unchanged", mem[12'hF11], 32'h489);

    run_dir("csrrs_nonexist", mk(12'h7C0, 5'd0, 3'b010, 5'd2), 32'h0,
            2, 0, 3, 3, 4, 5'd0, 32'h0, 0);

    run_dir("funct3_000", mk(12'h340, 5'd3, 3'b000, 5'd4), 32'h5,
            0, 0, 1, 1, 2, 5'd0, 32'h0, 0);

    run_dir("csrrc_ro_read", mk(12'hF11, 5'd0, 3'b011, 5'd3), 32'hFFFF_FFFF,
            2, 3, 0, 3, 4, 5'd3, 32'h489, 1);

    // Reset during cycle 1 of a CSRRW: request must vanish without any pulse.
    issue(mk(12'h340, 5'd6, 3'b001, 5'd5), 32'hCAFE0000);
    #2 rst = 1'b1;
    #1;
    chk("midrst req_valid",   32'(req_valid),   32'd0);
    chk("midrst issue_ready", 32'(issue_ready), 32'd1);
    chk("midrst op_done",     32'(op_done),     32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("postrst issue_ready", 32'(issue_ready), 32'd1);
      chk("postrst pulses", 32'({wb_valid, ex_valid, op_done, req_valid}), 32'd0);
    end
    chk("postrst mscratch", mem[12'h340], 32'hDEADBEEF);

    rand_en = 1;
    for (int n = 0; n < 300; n++) begin
      logic [11:0] a;
      logic [4:0]  src, rd;
      a   = csrs[$urandom_range(0, 9)];
      src = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
      rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(mk(a, src, 3'($urandom), rd), $urandom);
      if ($urandom_range(0, 29) == 0) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #3 rst = 1'b1;
        #4 rst = 1'b0;
      end
    end
    repeat (6) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/csr_exec.md
# csr_exec

CSR execution unit: accepts one decoded-at-entry CSR instruction (CSRRW/S/C and immediate forms) from dispatch, checks legality, drives the `csrfile` request channel, and returns the old CSR value for register writeback or raises an illegal-instruction exception. It sits directly upstream of `csrfile`, between dispatch and the writeback/trap path. One instruction is in flight at a time.

## Interface
- No parameters.
- `clk`  in  1  clock.
- `rst`  in  1  async reset, active-high.
- `issue_valid`  in  1  instruction offered; dispatch asserts it only for non-speculative instructions.
- `issue_ready`  out  1  unit idle; issue fires on `issue_valid & issue_ready`.
- `issue_instr`  in  gpreg  raw instruction.
- `issue_rs1`  in  gpreg  rs1 value.
- `req`  decoupled.out  csr_req  to `csrfile`, with fields `a` (csr_addr), `t` (CSRW/CSRS/CSRC), and `d` (gpreg).
- `resp`  in  csr_resp  from `csrfile`, with fields `exists` and `d`.
- `wb_valid`  out  1  one-cycle pulse: write `wb_data` to `wb_rd`.
- `wb_rd`  out  5  destination register.
- `wb_data`  out  gpreg  old CSR value.
- `ex_valid`  out  1  one-cycle pulse: illegal instruction.
- `ex_cause`  out  5  always 2 when `ex_valid` is high.
- `ex_tval`  out  gpreg  faulting instruction.
- `op_done`  out  1  one-cycle pulse on completion of every accepted instruction.

## Operation
- Decode at issue and latch the results:
  - funct3 = instr[14:12];
  - csr = instr[31:20];
  - src = instr[19:15], used as the rs1 index or as zimm;
  - rd = instr[11:7].
- Operand:
  - funct3[2] = 0: issue_rs1.
  - funct3[2] = 1: 32'(zimm), zero-extended.
- Type mapping (funct3[1:0]): 01 → CSRW, 10 → CSRS, 11 → CSRC.
- Illegal at issue (no request is sent):
  - funct3 ∈ {000, 100};
  - a write attempt to a read-only CSR (csr[11:10] == 2'b11).
  - A write attempt is any CSRRW/CSRRWI, or CSRRS/CSRRC[I] with src ≠ 0.
- Read-only accesses (S/C with src = 0) are issued as CSRS with d = 0.
  - The csrfile still commits read|0. For counter CSRs this re-writes the value sampled one cycle earlier, so one increment is lost per read. This is accepted for this revision.
- Nonexistent CSR: resp.exists = 0 at the handshake raises an exception. csrfile ignores the write.
- FSM states: IDLE, REQ, DONE.
  - IDLE: issue_ready = 1. On fire, latch the decode, then go to REQ, or to DONE with an illegal flag.
  - REQ: req.valid = 1, with req.data stable from latches. On req.ready, capture resp.d and resp.exists, then go to DONE.
  - DONE: pulse op_done. Pulse either ex_valid or wb_valid (the latter only if rd ≠ 0). Then go to IDLE.
- ex_valid and wb_valid are never asserted together. On an exception, rd is not written.
- Once REQ is entered the access is irrevocable; there is no flush input.

## Timing
- Reset values:
  - state IDLE, so issue_ready = 1;
  - req.valid, wb_valid, ex_valid, op_done = 0;
  - wb_rd, wb_data, ex_tval = 0; ex_cause = 2.
- Reset asserted mid-operation: return to IDLE asynchronously and drop req.valid immediately. No pulse is emitted.
- Legal op, issue fires at edge E0:
  - cycle 1: REQ, req.valid = 1. csrfile samples the request and enters COMMIT at E1.
  - cycle 2: req.ready = 1 and resp is valid; the unit captures it at E2. csrfile commits its write at E2.
  - cycle 3: DONE pulses.
  - cycle 4: IDLE, issue_ready = 1.
- Illegal-at-issue op: DONE in cycle 1, IDLE in cycle 2.
- req.valid and req.data stay stable from cycle 1 until and including the handshake cycle. req.valid is low in DONE, so csrfile never sees back-to-back requests.
- If req.ready is delayed, the unit holds REQ indefinitely.
- Throughput: one legal op per 4 cycles.
- Outputs are registered from state/latches. No combinational path from resp to req.

## Test plan
- CSRRW x5, mscratch (0x340), rs1 = 0xDEADBEEF, old value 0x11:
  - wb_valid in cycle 3, rd = 5, data = 0x11;
  - mscratch reads back 0xDEADBEEF;
  - issue_ready returns in cycle 4.
- CSRRSI x0, mstatus (0x300), zimm = 8:
  - no wb_valid; op_done pulses;
  - mstatus bit 3 set.
- CSRRS x7, mcycle, x0:
  - wb_data equals the cycle count sampled at the handshake;
  - no exception.
- CSRRW x1, mvendorid (0xF11), rs1 = 1:
  - ex_valid in cycle 1, cause 2, tval = instr;
  - req.valid never asserted.
- CSRRS x2, 0x7C0 (nonexistent), x0:
  - ex_valid in cycle 3, no wb_valid.
- rst asserted in cycle 1 of a CSRRW:
  - req.valid drops immediately; no pulses;
  - issue_ready = 1 after release.
